// File: rtl/icache_pkg.sv
// Shared types and width helpers for the N-way round-robin instruction cache.
package icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    // A direct-mapped build still needs a 1-bit way index to keep vectors legal.
    function automatic int waybits(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    localparam int DEF_ADDRWIDTH     = 32;
    localparam int DEF_WORDSPERBLOCK = 4;
    localparam int DEF_NUMOFSETS     = 64;
    localparam int DEF_NUMWAYS       = 2;

    localparam int SETBITS  = clog2(DEF_NUMOFSETS);
    localparam int WORDBITS = clog2(DEF_WORDSPERBLOCK);
    localparam int TAGBITS  = DEF_ADDRWIDTH - SETBITS - WORDBITS - 2;
    localparam int WAYBITS  = waybits(DEF_NUMWAYS);

endpackage

// File: rtl/icache_nway_rr_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_nway_rr_if
    import icache_pkg::*;
#(
    parameter int ADDRWIDTH = DEF_ADDRWIDTH
);
    logic [ADDRWIDTH-1:0] instraddress;
    logic [31:0]          ifetch;
    logic                 iready;
    logic                 flush;
    logic [31:0]          instruction;
    logic                 hit;
    logic                 miss;
    logic                 fetchreq;
    logic [ADDRWIDTH-1:0] fetchaddr;

    modport master (
        output instraddress, ifetch, iready, flush,
        input  instruction, hit, miss, fetchreq, fetchaddr
    );

    modport slave (
        input  instraddress, ifetch, iready, flush,
        output instruction, hit, miss, fetchreq, fetchaddr
    );
endinterface

// File: rtl/icache_victim_sel.sv
// Victim choice: lowest invalid way, else the set's round-robin pointer.
module icache_victim_sel
    import icache_pkg::*;
#(
    parameter int NUMOFSETS = DEF_NUMOFSETS,
    parameter int NUMWAYS   = DEF_NUMWAYS,
    parameter int SET_W     = clog2(NUMOFSETS),
    parameter int WAY_W     = waybits(NUMWAYS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SET_W-1:0]   index,
    input  logic [NUMWAYS-1:0] valid,
    input  logic               adv,
    input  logic [SET_W-1:0]   adv_index,
    output logic [WAY_W-1:0]   victim,
    output logic               use_ptr
);
    logic [NUMOFSETS-1:0][WAY_W-1:0] ptr_q, ptr_d;

    always_comb begin
        victim  = ptr_q[index];
        use_ptr = 1'b1;
        for (int w = NUMWAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim  = WAY_W'(w);
                use_ptr = 1'b0;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv)
            ptr_d[adv_index] = WAY_W'((int'(ptr_q[adv_index]) + 1) % NUMWAYS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/icache_nway_rr.sv
// N-way set-associative icache: registered 1-cycle hit, blocking word-per-cycle
// block refill that returns the requested word on completion.
module icache_nway_rr
    import icache_pkg::*;
#(
    parameter int ADDRWIDTH     = DEF_ADDRWIDTH,
    parameter int WORDSPERBLOCK = DEF_WORDSPERBLOCK,
    parameter int NUMOFSETS     = DEF_NUMOFSETS,
    parameter int NUMWAYS       = DEF_NUMWAYS
) (
    input logic            clk,
    input logic            reset,
    icache_nway_rr_if.slave bus
);
    localparam int SET_W  = clog2(NUMOFSETS);
    localparam int WORD_W = clog2(WORDSPERBLOCK);
    localparam int TAG_W  = ADDRWIDTH - SET_W - WORD_W - 2;
    localparam int WAY_W  = waybits(NUMWAYS);
    localparam logic [WORD_W-1:0] LAST = WORD_W'(WORDSPERBLOCK - 1);

    state_e                            state_q, state_d;
    logic [NUMOFSETS-1:0][NUMWAYS-1:0] valid_q, valid_d;
    logic [WORD_W-1:0]                 cnt_q, cnt_d;
    logic                              fpend_q, fpend_d;
    logic [31:0]                       instr_q, instr_d;
    logic                              hit_q, hit_d, miss_q, miss_d, freq_q, freq_d;
    logic [ADDRWIDTH-1:0]              faddr_q, faddr_d;
    logic [TAG_W-1:0]                  rtag_q, rtag_d;
    logic [SET_W-1:0]                  ridx_q, ridx_d;
    logic [WORD_W-1:0]                 roff_q, roff_d;
    logic [WAY_W-1:0]                  rway_q, rway_d;
    logic                              rptr_q, rptr_d;

    logic [31:0]      data_mem [NUMOFSETS][NUMWAYS][WORDSPERBLOCK];
    logic [TAG_W-1:0] tag_mem  [NUMOFSETS][NUMWAYS];
    logic [31:0]      line_buf [WORDSPERBLOCK];

    logic [TAG_W-1:0]  tag;
    logic [SET_W-1:0]  idx;
    logic [WORD_W-1:0] off;
    logic              lookup_hit, we, fill_done, adv, vic_ptr;
    logic [WAY_W-1:0]  hit_way, victim;
    logic              unused_lowbits;

    assign tag            = bus.instraddress[ADDRWIDTH-1 -: TAG_W];
    assign idx            = bus.instraddress[WORD_W+2 +: SET_W];
    assign off            = bus.instraddress[WORD_W+1:2];
    assign unused_lowbits = ^bus.instraddress[1:0];

    always_comb begin
        lookup_hit = 1'b0;
        hit_way    = '0;
        for (int w = 0; w < NUMWAYS; w++) begin
            if (!lookup_hit && valid_q[idx][w] && tag_mem[idx][w] == tag) begin
                lookup_hit = 1'b1;
                hit_way    = WAY_W'(w);
            end
        end
    end

    icache_victim_sel #(
        .NUMOFSETS(NUMOFSETS), .NUMWAYS(NUMWAYS), .SET_W(SET_W), .WAY_W(WAY_W)
    ) u_victim (
        .clk(clk), .rst(reset), .index(idx), .valid(valid_q[idx]),
        .adv(adv), .adv_index(ridx_q), .victim(victim), .use_ptr(vic_ptr)
    );

    assign we        = (state_q == REFILL) && bus.iready;
    assign fill_done = we && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        fpend_d = fpend_q;
        instr_d = instr_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        freq_d  = 1'b0;
        faddr_d = '0;
        rtag_d  = rtag_q;
        ridx_d  = ridx_q;
        roff_d  = roff_q;
        rway_d  = rway_q;
        rptr_d  = rptr_q;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush || fpend_q) begin
                    valid_d = '0;
                    fpend_d = 1'b0;
                end else if (lookup_hit) begin
                    hit_d   = 1'b1;
                    instr_d = data_mem[idx][hit_way][off];
                end else begin
                    miss_d  = 1'b1;
                    freq_d  = 1'b1;
                    faddr_d = {bus.instraddress[ADDRWIDTH-1:WORD_W+2], {(WORD_W+2){1'b0}}};
                    rtag_d  = tag;
                    ridx_d  = idx;
                    roff_d  = off;
                    rway_d  = victim;
                    rptr_d  = vic_ptr;
                    cnt_d   = '0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                miss_d  = 1'b1;
                freq_d  = 1'b1;
                faddr_d = faddr_q;
                if (bus.flush) fpend_d = 1'b1;
                if (bus.iready) begin
                    cnt_d   = cnt_q + WORD_W'(1);
                    faddr_d = faddr_q + ADDRWIDTH'(4);
                    if (cnt_q == LAST) begin
                        valid_d[ridx_q][rway_q] = 1'b1;
                        adv     = rptr_q;
                        // Earlier words of the line come from the buffer, the last one straight off the bus.
                        instr_d = (roff_q == LAST) ? bus.ifetch : line_buf[roff_q];
                        hit_d   = 1'b1;
                        miss_d  = 1'b0;
                        freq_d  = 1'b0;
                        faddr_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            cnt_q   <= '0;
            fpend_q <= 1'b0;
            instr_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            freq_q  <= 1'b0;
            faddr_q <= '0;
            rtag_q  <= '0;
            ridx_q  <= '0;
            roff_q  <= '0;
            rway_q  <= '0;
            rptr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            fpend_q <= fpend_d;
            instr_q <= instr_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            freq_q  <= freq_d;
            faddr_q <= faddr_d;
            rtag_q  <= rtag_d;
            ridx_q  <= ridx_d;
            roff_q  <= roff_d;
            rway_q  <= rway_d;
            rptr_q  <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            data_mem[ridx_q][rway_q][cnt_q] <= bus.ifetch;
            line_buf[cnt_q]                 <= bus.ifetch;
        end
        if (fill_done) tag_mem[ridx_q][rway_q] <= rtag_q;
    end

    assign bus.instruction = instr_q;
    assign bus.hit         = hit_q;
    assign bus.miss        = miss_q;
    assign bus.fetchreq    = freq_q;
    assign bus.fetchaddr   = faddr_q;
endmodule

// File: tb/tb_icache_nway_rr.sv
// Bench for icache_nway_rr: directed vector table, hand-written corner
// sequences and a randomized phase checked against a transaction-level model.
module tb_icache_nway_rr;
    localparam int NS  = 64;
    localparam int NW  = 2;
    localparam int WPB = 4;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    icache_nway_rr_if #(.ADDRWIDTH(32)) bus ();

    icache_nway_rr #(
        .ADDRWIDTH(32), .WORDSPERBLOCK(WPB), .NUMOFSETS(NS), .NUMWAYS(NW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: which block base each way of each set holds, plus the rr pointer.
    bit          mv   [NS][NW];
    logic [31:0] mtag [NS][NW];
    int          mrr  [NS];

    typedef struct {
        logic [31:0] addr;
        int          gap_at;
        int          gap_len;
        int          flush_at;
        bit          exp_hit;
    } vec_t;
    vec_t tbl [16];

    function automatic logic [31:0] memw(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (w[31:4] == 28'h100) return 32'hA0 + 32'(w[3:2]);
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_clear(input bit ptrs);
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) mv[s][w] = 1'b0;
            if (ptrs) mrr[s] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [31:0] addr, input int gap_at, input int gap_len,
                          input int flush_at, input bit use_tbl, input bit tbl_hit,
                          input string nm);
        logic [31:0] base;
        int          s, way;
        bit          mhit, exph;
        base = addr & ~32'(WPB * 4 - 1);
        s    = int'((addr >> 4) % NS);
        mhit = 1'b0;
        for (int w = 0; w < NW; w++)
            if (mv[s][w] && mtag[s][w] == base) mhit = 1'b1;
        exph = use_tbl ? tbl_hit : mhit;
        bus.instraddress = addr;
        bus.flush        = 1'b0;
        bus.iready       = 1'b0;
        step();
        check({nm, ".hit"}, 32'(bus.hit), 32'(exph));
        check({nm, ".miss"}, 32'(bus.miss), 32'(!exph));
        if (exph) begin
            check({nm, ".instr"}, bus.instruction, memw(addr));
            check({nm, ".fetchreq"}, 32'(bus.fetchreq), 32'd0);
        end else begin
            check({nm, ".fetchreq"}, 32'(bus.fetchreq), 32'd1);
            check({nm, ".fetchaddr0"}, bus.fetchaddr, base);
            way = -1;
            for (int w = 0; w < NW; w++)
                if (!mv[s][w] && way < 0) way = w;
            if (way < 0) begin
                way    = mrr[s];
                mrr[s] = (mrr[s] + 1) % NW;
            end
            for (int k = 0; k < WPB; k++) begin
                if (k == gap_at) begin
                    for (int g = 0; g < gap_len; g++) begin
                        bus.iready       = 1'b0;
                        bus.flush        = 1'b0;
                        bus.instraddress = $urandom;
                        step();
                        check({nm, ".gap_faddr"}, bus.fetchaddr, base + 32'(4 * k));
                        check({nm, ".gap_miss"}, 32'(bus.miss), 32'd1);
                    end
                end
                bus.iready       = 1'b1;
                bus.ifetch       = memw(base + 32'(4 * k));
                bus.flush        = (k == flush_at);
                bus.instraddress = $urandom;
                step();
                if (k < WPB - 1) begin
                    check({nm, ".faddr"}, bus.fetchaddr, base + 32'(4 * (k + 1)));
                    check({nm, ".rf_miss"}, 32'(bus.miss), 32'd1);
                end else begin
                    check({nm, ".fill_hit"}, 32'(bus.hit), 32'd1);
                    check({nm, ".fill_miss"}, 32'(bus.miss), 32'd0);
                    check({nm, ".fill_freq"}, 32'(bus.fetchreq), 32'd0);
                    check({nm, ".fill_faddr"}, bus.fetchaddr, 32'd0);
                    check({nm, ".fill_instr"}, bus.instruction, memw(addr));
                end
            end
            bus.iready = 1'b0;
            bus.flush  = 1'b0;
            mv[s][way]   = 1'b1;
            mtag[s][way] = base;
            if (flush_at >= 0) begin
                bus.instraddress = addr;
                step();
                check({nm, ".pflush_hit"}, 32'(bus.hit), 32'd0);
                check({nm, ".pflush_miss"}, 32'(bus.miss), 32'd0);
                model_clear(1'b0);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{32'h0000_1008, -1, 0, -1, 1'b0};
        tbl[1]  = '{32'h0000_1008, -1, 0, -1, 1'b1};
        tbl[2]  = '{32'h0000_100C, -1, 0, -1, 1'b1};
        tbl[3]  = '{32'h0000_1408, -1, 0, -1, 1'b0};
        tbl[4]  = '{32'h0000_1008, -1, 0, -1, 1'b1};
        tbl[5]  = '{32'h0000_1408, -1, 0, -1, 1'b1};
        tbl[6]  = '{32'h0000_1808, -1, 0, -1, 1'b0};
        tbl[7]  = '{32'h0000_1408, -1, 0, -1, 1'b1};
        tbl[8]  = '{32'h0000_1008, -1, 0, -1, 1'b0};
        tbl[9]  = '{32'h0000_1808, -1, 0, -1, 1'b1};
        tbl[10] = '{32'h0000_2044,  2, 3, -1, 1'b0};
        tbl[11] = '{32'h0000_2048, -1, 0, -1, 1'b1};
        tbl[12] = '{32'h0000_2000, -1, 0,  1, 1'b0};
        tbl[13] = '{32'h0000_2000, -1, 0, -1, 1'b0};
        tbl[14] = '{32'h0000_1008, -1, 0, -1, 1'b0};
        tbl[15] = '{32'h0000_200F, -1, 0, -1, 1'b1};

        model_clear(1'b1);
        reset            = 1'b1;
        bus.instraddress = '0;
        bus.ifetch       = '0;
        bus.iready       = 1'b0;
        bus.flush        = 1'b0;
        repeat (3) step();
        check("rst.instr", bus.instruction, 32'd0);
        check("rst.hit", 32'(bus.hit), 32'd0);
        check("rst.miss", 32'(bus.miss), 32'd0);
        check("rst.fetchreq", 32'(bus.fetchreq), 32'd0);
        check("rst.fetchaddr", bus.fetchaddr, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++)
            access(tbl[i].addr, tbl[i].gap_at, tbl[i].gap_len, tbl[i].flush_at,
                   1'b1, tbl[i].exp_hit, $sformatf("tbl%0d", i));

        // Flush in IDLE wins over a lookup that would hit.
        bus.instraddress = 32'h0000_1008;
        bus.flush        = 1'b1;
        step();
        check("iflush.hit", 32'(bus.hit), 32'd0);
        check("iflush.miss", 32'(bus.miss), 32'd0);
        bus.flush = 1'b0;
        model_clear(1'b0);
        access(32'h0000_1008, -1, 0, -1, 1'b1, 1'b0, "after_iflush");

        // Reset during the second refill word aborts the fill.
        bus.instraddress = 32'h0000_3000;
        step();
        check("rmid.miss", 32'(bus.miss), 32'd1);
        bus.iready = 1'b1;
        bus.ifetch = memw(32'h3000);
        step();
        bus.ifetch = memw(32'h3004);
        #3;
        reset = 1'b1;
        #1;
        check("rmid.hit", 32'(bus.hit), 32'd0);
        check("rmid.miss0", 32'(bus.miss), 32'd0);
        check("rmid.fetchreq", 32'(bus.fetchreq), 32'd0);
        check("rmid.fetchaddr", bus.fetchaddr, 32'd0);
        check("rmid.instr", bus.instruction, 32'd0);
        step();
        reset      = 1'b0;
        bus.iready = 1'b0;
        model_clear(1'b1);
        access(32'h0000_3000, -1, 0, -1, 1'b1, 1'b0, "rmid_reread");

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            int          fa;
            if ($urandom_range(0, 19) == 0) begin
                bus.instraddress = $urandom;
                bus.flush        = 1'b1;
                step();
                check("rnd_iflush.hit", 32'(bus.hit), 32'd0);
                check("rnd_iflush.miss", 32'(bus.miss), 32'd0);
                bus.flush = 1'b0;
                model_clear(1'b0);
            end
            a = 32'h0004_0000 + (32'($urandom_range(0, 5)) << 10)
                + (32'($urandom_range(0, 3)) << 4) + (32'($urandom_range(0, 3)) << 2)
                + 32'($urandom_range(0, 3));
            fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WPB - 1)) : -1;
            access(a, int'($urandom_range(0, WPB)), int'($urandom_range(1, 3)), fa,
                   1'b0, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_nway_rr.md
Name: icache_nway_rr

Overview:
- Parametrised N-way set-associative instruction cache. Successor to the direct-mapped, multi-word-block icache.
- Sits between the fetch stage and instruction memory. Registered 1-cycle hit path; blocking refill of a whole block over a word-per-cycle memory handshake.
- Adds over the previous generation:
  - configurable ways, sets and address width
  - invalid-first / round-robin victim selection
  - explicit memory request strobe and a full-cache flush
  - on refill completion, returns the *requested* word, not the last word fetched

Parameters:
- ADDRWIDTH, 32: instruction address width. TAGBITS = ADDRWIDTH - SETBITS - WORDBITS - 2.
- WORDSPERBLOCK, 4: 32-bit words per line. Power of 2, 2..16. WORDBITS = clog2.
- NUMOFSETS, 64: number of sets. Power of 2, 2..1024. SETBITS = clog2.
- NUMWAYS, 2: associativity. Power of 2, 1..8. NUMWAYS=1 degenerates to direct-mapped.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- instraddress  in  ADDRWIDTH  fetch address; bits [1:0] ignored
- ifetch  in  32  refill word from memory
- iready  in  1  ifetch valid this cycle
- flush  in  1  invalidate all lines
- instruction  out  32  fetched instruction; valid when hit=1
- hit  out  1  instruction valid this cycle
- miss  out  1  cache stalled on refill
- fetchreq  out  1  memory request active
- fetchaddr  out  ADDRWIDTH  address of the word requested from memory

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all valid bits=0; all round-robin pointers=0; fetch_count=0; pending flush=0.
  - Outputs: instruction=0, hit=0, miss=0, fetchreq=0, fetchaddr=0.
  - Data and tag arrays are not reset; valid bits guard them.
- Address split: tag=[ADDRWIDTH-1 -: TAGBITS], index=next SETBITS bits, word offset=[WORDBITS+1:2].
- IDLE, flush=1:
  - Clear every valid bit at this edge. hit=0, miss=0, no lookup.
  - flush has priority over lookup.
- IDLE lookup, flush=0:
  - Compare the tag against all ways of the indexed set in parallel.
  - Hit: on the next edge, instruction=data[index][way][offset], hit=1, miss=0, fetchreq=0, fetchaddr=0. Latency 1 cycle, throughput 1 per cycle.
  - Miss: on the next edge, hit=0, miss=1, fetchreq=1, fetchaddr={instraddress block base, low bits 0}. Capture tag, index, offset and victim way. fetch_count=0. Go to REFILL.
- Victim selection: lowest-numbered invalid way if any; otherwise the way given by the set's round-robin pointer.
- REFILL:
  - instraddress is ignored; hit=0, miss=1, fetchreq=1.
  - Each cycle with iready=1: data[idx][victim][fetch_count]=ifetch, fetch_count+1, fetchaddr+4.
  - iready=0: hold all state and outputs. No timeout.
  - Last word (fetch_count==WORDSPERBLOCK-1 with iready=1):
    - write tag, set valid.
    - If the victim was chosen by the pointer, advance the set's pointer mod NUMWAYS.
    - instruction = captured-offset word. This is the final ifetch if offset==last, otherwise the previously written word, bypassed from the refill line buffer.
    - hit=1, miss=0, fetchreq=0, fetchaddr=0. Go to IDLE.
- flush during REFILL:
  - Latched as pending; the refill completes normally and still delivers hit=1.
  - On the first IDLE edge afterwards, the pending flush runs, clearing all valid bits including the new line; hit=miss=0 that cycle.
- Hit cycle immediately after refill: the next address is looked up in IDLE on the following edge. The new line is visible to it.
- Reset mid-REFILL: abort, state=IDLE, victim line stays invalid, partial data is discarded.
- fetch_count is WORDBITS wide. Wrap on the last word is expected and harmless.

Decomposition:
- Package icache_pkg:
  - state enum {IDLE, REFILL}
  - clog2 function
  - derived widths: SETBITS, WORDBITS, TAGBITS, WAYBITS
- Sub-module icache_victim_sel:
  - holds the per-set round-robin pointer array (async reset to 0)
  - inputs: index, valid vector; output: victim way
  - advance strobe from the parent

Test Plan (defaults; index = addr[9:4], offset = addr[3:2]):
- Cold read 0x0000_1008 -> miss=1, fetchreq=1, fetchaddr=0x1000. Drive iready with words 0xA0..0xA3 -> fetchaddr steps 0x1004..0x100C; on last word, hit=1, instruction=0xA2, way 0 valid.
- Re-read 0x0000_1008, then 0x0000_100C on the next cycle -> hits at 1-cycle latency, 0xA2 then 0xA3, fetchreq=0.
- 0x0000_1408 and 0x0000_1808 (same set 0):
  - 0x1408 fills way 1; both lines then hit.
  - 0x1808 evicts way 0 (pointer 0 -> 1); 0x1008 then misses, 0x1408 still hits.
- iready gaps: hold iready=0 for 3 cycles between words 1 and 2 -> fetchaddr, miss and fetch_count hold; the correct word is returned.
- flush mid-refill of 0x2000:
  - Refill completes with hit=1 and the correct word; the next cycle has hit=miss=0.
  - A subsequent read of 0x2000 misses again.
- Assert reset during the 2nd refill word -> all outputs 0 immediately; the re-read misses.
